// File: rtl/segment_display_ctrl.sv
// Eight-digit multiplexed seven-segment driver for CPU debug values.
// Three pages are selected by a debounced button; inputs are latched once per frame.
module segment_display_ctrl #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_btn_page,
    input  logic [15:0] i_alu_P,
    input  logic [15:0] i_alu_Q,
    input  logic [15:0] i_alu_result_low,
    input  logic [15:0] i_alu_result_high,
    input  logic [2:0]  i_alu_op,
    input  logic [7:0]  i_max_addr,
    input  logic        i_halt,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic [7:0]  o_an,
    output logic [1:0]  o_page
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] q;
        logic [15:0] rl;
        logic [15:0] rh;
        logic [2:0]  op;
        logic [7:0]  addr;
        logic        halt;
        logic [1:0]  page;
    } snap_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]    page_q, page_d;
    logic [SW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    idx_q, idx_d;
    snap_t         snap_q, snap_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick;
    snap_t         live;
    snap_t         cur;
    logic [31:0]   word;
    logic [3:0]    nib;
    logic          blank;
    logic          dp_on;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] h;
        h = 7'h7F;
        unique case (v)
            4'h0: h = 7'h40;
            4'h1: h = 7'h79;
            4'h2: h = 7'h24;
            4'h3: h = 7'h30;
            4'h4: h = 7'h19;
            4'h5: h = 7'h12;
            4'h6: h = 7'h02;
            4'h7: h = 7'h78;
            4'h8: h = 7'h00;
            4'h9: h = 7'h10;
            4'hA: h = 7'h08;
            4'hB: h = 7'h03;
            4'hC: h = 7'h46;
            4'hD: h = 7'h21;
            4'hE: h = 7'h06;
            4'hF: h = 7'h0E;
        endcase
        return h;
    endfunction

    // Button: synchronize, debounce, advance the page on an accepted press.
    always_comb begin
        sync1_d   = i_btn_page;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        page_d    = page_q;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
                if (sync2_q) begin
                    page_d = (page_q == 2'd2) ? 2'd0 : page_q + 2'd1;
                end
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    always_comb begin
        live.p    = i_alu_P;
        live.q    = i_alu_Q;
        live.rl   = i_alu_result_low;
        live.rh   = i_alu_result_high;
        live.op   = i_alu_op;
        live.addr = i_max_addr;
        live.halt = i_halt;
        live.page = page_q;
    end

    // Digit 0 opens a frame and must show the values being captured.
    assign cur = (idx_q == 3'd0) ? live : snap_q;

    always_comb begin
        word = 32'h0;
        unique case (cur.page)
            2'd0:    word = {cur.p, cur.q};
            2'd1:    word = {cur.rh, cur.rl};
            default: word = {1'b0, cur.op, 20'h0, cur.addr};
        endcase
        nib   = word[{idx_q, 2'b00} +: 4];
        blank = (cur.page == 2'd3) ||
                ((cur.page == 2'd2) && (idx_q >= 3'd2) && (idx_q <= 3'd6));
        dp_on = ((idx_q == 3'd4) && (cur.page < 2'd2)) ||
                ((idx_q == 3'd0) && cur.halt);
    end

    always_comb begin
        tick       = (tick_cnt_q == SCAN_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + SW'(1);
        idx_d      = idx_q;
        snap_d     = snap_q;
        an_d       = an_q;
        seg_d      = seg_q;
        dp_d       = dp_q;
        if (tick) begin
            idx_d = idx_q + 3'd1;
            an_d  = ~(8'h01 << idx_q);
            seg_d = blank ? 7'h7F : hex7(nib);
            dp_d  = ~dp_on;
            if (idx_q == 3'd0) begin
                snap_d = live;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_cnt_q  <= '0;
            page_q     <= 2'd0;
            tick_cnt_q <= '0;
            idx_q      <= 3'd0;
            snap_q     <= '0;
            an_q       <= 8'hFF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            page_q     <= page_d;
            tick_cnt_q <= tick_cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign o_an   = an_q;
    assign o_seg  = seg_q;
    assign o_dp   = dp_q;
    assign o_page = page_q;

endmodule
